// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input stream and held frame-result handshake.
`timescale 1ns/1ps
interface product_accumulator_if #(
  parameter int N = 32,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
);
  logic in_valid, in_ready, in_last, out_valid, out_ready, overflow;
  logic [2*N-1:0] product;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] term_count;
  modport master(
    output in_valid, product, in_last, out_ready,
    input in_ready, out_valid, acc_out, term_count, overflow
  );
  modport slave(
    input in_valid, product, in_last, out_ready,
    output in_ready, out_valid, acc_out, term_count, overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: saturating signed multiply-accumulate back end with a held frame result.
`timescale 1ns/1ps
module product_accumulator #(
  parameter int N = 32,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  product_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_n;
  logic accept, sat;
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] acc_next;
  if (ACC_W < 2*N+1) begin : g_width_check
    $error("product_accumulator: ACC_W must be >= 2N+1");
  end
  assign bus.in_ready = state == ACCUM;
  assign bus.out_valid = state == HOLD;
  always_comb begin
    accept = bus.in_valid && state == ACCUM;
    sum = {bus.acc_out[ACC_W-1], bus.acc_out} + {{(ACC_W+1-2*N){bus.product[2*N-1]}}, bus.product};
    sat = sum[ACC_W] != sum[ACC_W-1];
    // top bit of the wide sum gives the true sign, so it picks the clamp direction
    acc_next = sat ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
    state_n = state == ACCUM ? (accept && bus.in_last ? HOLD : ACCUM) : (bus.out_ready ? ACCUM : HOLD);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACCUM;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.acc_out <= '0;
      bus.term_count <= '0;
      bus.overflow <= 1'b0;
    end else if (state == HOLD && bus.out_ready) begin
      bus.acc_out <= '0;
      bus.term_count <= '0;
      bus.overflow <= 1'b0;
    end else if (accept) begin
      bus.acc_out <= acc_next;
      bus.term_count <= &bus.term_count ? bus.term_count : bus.term_count + 1'b1;
      bus.overflow <= bus.overflow | sat;
    end
endmodule
